// File: rtl/cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } cfg_ld_state_t;

    // Interconnect select width and number of selectable sources per LE input.
    localparam int unsigned CFG_SEL_BITS = 3;
    localparam int unsigned LE_OUTS      = 4;

    // Config chain length contributed by an interconnect with le_inputs inputs.
    function automatic int unsigned cfg_chain_len(input int unsigned le_inputs);
        return le_inputs * LE_OUTS * CFG_SEL_BITS;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Hold/shift register for one bitstream word; emits it MSB-first, one bit per shift.
module cfg_word_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         load,
    input  logic [WORD_W-1:0]            load_data,
    input  logic [$clog2(WORD_W+1)-1:0]  load_bits,
    input  logic                         run,
    output logic                         hold_valid,
    output logic                         last_bit,
    output logic                         cfg_sdo
);

    localparam int unsigned BitCntW = $clog2(WORD_W + 1);
    localparam logic [BitCntW-1:0] BitOne = 1;

    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [BitCntW-1:0] bits_q, bits_d;
    logic               hold_q, hold_d;
    logic               shifting;

    assign shifting   = hold_q && run;
    assign last_bit   = shifting && (bits_q == BitOne);
    assign hold_valid = hold_q;
    assign cfg_sdo    = shift_q[WORD_W-1];

    // Next-state: flush beats a new word, a new word beats a plain shift.
    always_comb begin
        shift_d = shift_q;
        bits_d  = bits_q;
        hold_d  = hold_q;
        if (flush) begin
            shift_d = '0;
            bits_d  = '0;
            hold_d  = 1'b0;
        end else if (load) begin
            shift_d = load_data;
            bits_d  = load_bits;
            hold_d  = 1'b1;
        end else if (shifting) begin
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            bits_d  = bits_q - BitOne;
            hold_d  = (bits_q != BitOne);
        end
    end

    // Hold register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bits_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bits_q  <= bits_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/cfg_stream_loader.sv
// Word-to-serial loader driving the fabric configuration shift chain.
module cfg_stream_loader
    import cfg_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = cfg_chain_len(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_mode,
    output logic              cfg_shift,
    output logic              cfg_sdo,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned ChainCntW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WordCntW  = $clog2(NWORDS + 1);
    localparam int unsigned BitCntW   = $clog2(WORD_W + 1);

    localparam logic [ChainCntW-1:0] ChainOne = 1;
    localparam logic [WordCntW-1:0]  WordOne  = 1;

    cfg_ld_state_t        state_q, state_d;
    logic [ChainCntW-1:0] chain_left_q, chain_left_d;
    logic [WordCntW-1:0]  words_left_q, words_left_d;
    logic                 err_q, err_d;

    logic                 hold_valid;
    logic                 last_bit;
    logic                 in_load;
    logic                 shift_now;
    logic                 start_ok;
    logic                 abort_ok;
    logic                 final_shift;
    logic                 ready_int;
    logic                 accept;
    logic [ChainCntW-1:0] avail;
    logic [BitCntW-1:0]   load_bits;

    assign in_load     = (state_q == LOAD);
    assign shift_now   = hold_valid && in_load;
    assign start_ok    = start && !in_load;
    assign abort_ok    = abort && in_load;
    assign final_shift = shift_now && (chain_left_q == ChainOne);
    assign ready_int   = in_load && (words_left_q != '0) && (!hold_valid || last_bit);
    assign accept      = word_valid && ready_int;

    // Chain bits not yet covered by an accepted word: a word is only taken while the hold
    // register is empty or on its final bit, so at most one bit is in flight here.
    assign avail = chain_left_q - (shift_now ? ChainOne : '0);

    // A short final word only carries as many bits as the chain still needs.
    always_comb begin
        load_bits = BitCntW'(WORD_W);
        if (32'(avail) < WORD_W) begin
            load_bits = BitCntW'(avail);
        end
    end

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .flush      (start_ok || abort_ok),
        .load       (accept),
        .load_data  (word_data),
        .load_bits  (load_bits),
        .run        (in_load),
        .hold_valid (hold_valid),
        .last_bit   (last_bit),
        .cfg_sdo    (cfg_sdo)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort takes priority over completing the final shift.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (final_shift) begin
                    state_d = DONE;
                end
            end
            DONE: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and handshake.
    always_comb begin
        cfg_mode   = in_load;
        busy       = in_load;
        cfg_shift  = shift_now;
        done       = (state_q == DONE);
        err        = err_q;
        word_ready = ready_int;
    end

    // Chain/word counters and sticky error, next state.
    always_comb begin
        chain_left_d = chain_left_q;
        words_left_d = words_left_q;
        err_d        = err_q;
        if (start_ok) begin
            chain_left_d = ChainCntW'(CHAIN_LEN);
            words_left_d = WordCntW'(NWORDS);
            err_d        = 1'b0;
        end else if (abort_ok) begin
            chain_left_d = '0;
            words_left_d = '0;
            err_d        = 1'b1;
        end else begin
            if (shift_now) chain_left_d = chain_left_q - ChainOne;
            if (accept)    words_left_d = words_left_q - WordOne;
        end
    end

    // Counter and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_left_q <= '0;
            words_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            chain_left_q <= chain_left_d;
            words_left_q <= words_left_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench: scoreboard of expected serial bits against a modelled config chain.
module tb_cfg_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel, start, abort, word_valid;
    logic [7:0] word_data;
    logic       rst_a, rst_b;

    // DUT a: 48-bit chain, DUT b: 44-bit chain; only the selected one is out of reset.
    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;

    logic rdy_a, mode_a, shf_a, sdo_a, busy_a, done_a, err_a;
    logic rdy_b, mode_b, shf_b, sdo_b, busy_b, done_b, err_b;

    cfg_stream_loader #(
        .WORD_W    (8),
        .CHAIN_LEN (48)
    ) dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (rdy_a),
        .cfg_mode   (mode_a),
        .cfg_shift  (shf_a),
        .cfg_sdo    (sdo_a),
        .busy       (busy_a),
        .done       (done_a),
        .err        (err_a)
    );

    cfg_stream_loader #(
        .WORD_W    (8),
        .CHAIN_LEN (44)
    ) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (rdy_b),
        .cfg_mode   (mode_b),
        .cfg_shift  (shf_b),
        .cfg_sdo    (sdo_b),
        .busy       (busy_b),
        .done       (done_b),
        .err        (err_b)
    );

    logic m_ready, m_mode, m_shift, m_sdo, m_busy, m_done, m_err;
    assign m_ready = sel ? rdy_b  : rdy_a;
    assign m_mode  = sel ? mode_b : mode_a;
    assign m_shift = sel ? shf_b  : shf_a;
    assign m_sdo   = sel ? sdo_b  : sdo_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_err   = sel ? err_b  : err_a;

    logic [6:0] outs7;
    assign outs7 = {m_mode, m_shift, m_sdo, m_busy, m_done, m_err, m_ready};

    logic [7:0] words [6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

    // ---------------- monitor / scoreboard ----------------
    logic        exp_q [$];
    logic        mon_clr;
    int unsigned cyc = 0;
    int unsigned mon_shift_cnt, mon_gap_cnt, mon_acc_cnt, mon_sdo_err, mon_pushed;
    int unsigned mon_last_shift_cyc, mon_done_rise_cyc, mon_acc_first_cyc;
    logic        mon_first_shift, mon_acc_seen, mon_done_prev;
    logic [63:0] mon_chain;

    function automatic int unsigned bits_for(input int unsigned len, input int unsigned pushed);
        if (pushed >= len) return 0;
        if (len - pushed > 8) return 8;
        return len - pushed;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            exp_q.delete();
            mon_shift_cnt      <= 0;
            mon_gap_cnt        <= 0;
            mon_acc_cnt        <= 0;
            mon_sdo_err        <= 0;
            mon_pushed         <= 0;
            mon_last_shift_cyc <= 0;
            mon_done_rise_cyc  <= 0;
            mon_acc_first_cyc  <= 0;
            mon_first_shift    <= 1'b0;
            mon_acc_seen       <= 1'b0;
            mon_done_prev      <= m_done;
            mon_chain          <= '0;
        end else begin
            if (m_shift) begin
                mon_shift_cnt      <= mon_shift_cnt + 1;
                mon_chain          <= {mon_chain[62:0], m_sdo};
                mon_last_shift_cyc <= cyc;
                mon_first_shift    <= 1'b1;
                if (exp_q.size() == 0) begin
                    mon_sdo_err <= mon_sdo_err + 1;
                end else begin
                    if (exp_q[0] !== m_sdo) mon_sdo_err <= mon_sdo_err + 1;
                    void'(exp_q.pop_front());
                end
            end else if (m_mode && mon_first_shift) begin
                mon_gap_cnt <= mon_gap_cnt + 1;
            end
            if (word_valid && m_ready) begin
                mon_acc_cnt <= mon_acc_cnt + 1;
                if (!mon_acc_seen) begin
                    mon_acc_seen      <= 1'b1;
                    mon_acc_first_cyc <= cyc;
                end
                for (int i = 0; i < int'(bits_for(sel ? 44 : 48, mon_pushed)); i++) begin
                    exp_q.push_back(word_data[7-i]);
                end
                mon_pushed <= mon_pushed + bits_for(sel ? 44 : 48, mon_pushed);
            end
            if (m_done && !mon_done_prev) mon_done_rise_cyc <= cyc;
            mon_done_prev <= m_done;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer one word; with late>0, keep valid low for 'late' cycles of an open ready window.
    task automatic send_word(input logic [7:0] d, input int late);
        bit got;
        if (late > 0) begin
            got = 1'b0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge clk);
                got = m_ready;
            end
            if (!got) check_eq("ready_window_timeout", 0, 1);
            repeat (late) @(posedge clk);
            #1;
        end
        word_data  = d;
        word_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = m_ready;
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1 word_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = m_done;
        end
        if (!got) check_eq("done_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_shifts(input int unsigned cnt);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            #1 got = (mon_shift_cnt >= cnt);
        end
        if (!got) check_eq("shift_count_timeout", 0, 1);
    endtask

    // Full 48-bit load of 'words'; optional stall before word late_idx, optional start in LOAD.
    task automatic run_load(input int late_idx, input int late, input bit start_mid);
        mon_reset();
        do_start();
        check_eq("start_outs", {m_mode, m_busy, m_done, m_err}, 4'b1100);
        for (int i = 0; i < 6; i++) begin
            if (start_mid && i == 2) start = 1'b1;
            send_word(words[i], (i == late_idx) ? late : 0);
            start = 1'b0;
        end
        wait_done();
        check_eq("shift_count", mon_shift_cnt, 48);
        check_eq("stall_cycles", mon_gap_cnt, (late_idx >= 0) ? late : 0);
        check_eq("sdo_bit_errors", mon_sdo_err, 0);
        check_eq("chain_contents", mon_chain[47:0], 48'h0123456789AB);
        check_eq("words_accepted", mon_acc_cnt, 6);
        check_eq("done_after_last_shift", mon_done_rise_cyc - mon_last_shift_cyc, 1);
        check_eq("done_latency", mon_done_rise_cyc - mon_acc_first_cyc,
                 49 + ((late_idx >= 0) ? late : 0));
        repeat (2) @(negedge clk);
        check_eq("done_held_outs", {m_mode, m_shift, m_busy, m_done, m_err, m_ready}, 6'b000100);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst        = 1'b1;
        sel        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        mon_clr    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);
        check_eq("reset_outs", outs7, 0);
        repeat (3) @(negedge clk);
        check_eq("idle_without_start", outs7, 0);

        // Back-to-back load.
        run_load(-1, 0, 1'b0);

        // Valid withheld for three cycles in front of word 3.
        run_load(2, 3, 1'b0);

        // 44-bit chain: short last word, extra word refused.
        sel = 1'b1;
        @(negedge clk);
        check_eq("reset_outs_44", outs7, 0);
        mon_reset();
        do_start();
        words[5] = 8'hF0;
        for (int i = 0; i < 6; i++) send_word(words[i], 0);
        word_data  = 8'h55;
        word_valid = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);
        #1;
        check_eq("shift_count_44", mon_shift_cnt, 44);
        check_eq("sdo_bit_errors_44", mon_sdo_err, 0);
        check_eq("chain_contents_44", mon_chain[43:0], 44'h0123456789F);
        check_eq("words_accepted_44", mon_acc_cnt, 6);
        check_eq("extra_word_ready_44", m_ready, 0);
        check_eq("stall_cycles_44", mon_gap_cnt, 0);
        word_valid = 1'b0;
        words[5]   = 8'hAB;
        sel        = 1'b0;
        @(negedge clk);

        // Abort after 20 shifts, then a clean reload.
        mon_reset();
        do_start();
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        wait_shifts(20);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_outs", {m_mode, m_shift, m_busy, m_done, m_err, m_ready}, 6'b000010);
        repeat (3) @(negedge clk);
        check_eq("abort_err_sticky", {m_busy, m_err}, 2'b01);
        run_load(-1, 0, 1'b0);

        // start held during LOAD must not restart the load.
        run_load(-1, 0, 1'b1);

        // Reset in the middle of a load.
        mon_reset();
        do_start();
        for (int i = 0; i < 4; i++) send_word(words[i], 0);
        wait_shifts(30);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_load_outs", outs7, 0);
        check_eq("rst_mid_load_ready", m_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_after_rst", outs7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
